// File: rtl/duty_select_pkg.sv
// Shared types and limits for the duty_select control stage.
// Includes the saturating step helper used by the top-level FSM.
package duty_select_pkg;

  localparam logic [3:0] PW_MAX = 4'd15;
  localparam logic [3:0] PW_MIN = 4'd0;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  // A step at a limit returns the input unchanged, so callers detect a real change by comparison.
  function automatic logic [3:0] step_value(input logic [3:0] pw, input dir_t dir);
    logic [3:0] result;
    result = pw;
    if (dir == DIR_UP) begin
      if (pw != PW_MAX) result = pw + 4'd1;
    end else begin
      if (pw != PW_MIN) result = pw - 4'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/duty_select_button_debouncer.sv
// Two-flop synchroniser plus stability-counter debouncer for one raw push-button.
// btn_rise pulses for one clock in the same cycle btn_level first goes high.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk_1MHz,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_out;
  logic [CW-1:0] count;

  // The count only advances while the synchronised input disagrees with the accepted level.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
      count     <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync_out  <= sync_meta;
      btn_rise  <= 1'b0;
      if (sync_out == btn_level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        btn_level <= sync_out;
        btn_rise  <= sync_out;
        count     <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/duty_select.sv
// Turns debounced up/down buttons into a saturating 4-bit pulse_width code,
// stepping once per press and auto-repeating while a single button is held.
module duty_select
  import duty_select_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000,
  parameter int INIT_WIDTH      = 5
) (
  input  logic       clk_1MHz,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] pulse_width,
  output logic       step_pulse,
  output logic       at_max,
  output logic       at_min
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RCW-1:0] DELAY_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RATE_LAST  = RCW'(REPEAT_RATE - 1);
  localparam logic [3:0]     INIT_PW    = 4'(INIT_WIDTH);

  logic           up_level, up_rise;
  logic           dn_level, dn_rise;
  state_t         state, state_next;
  dir_t           dir, dir_next;
  logic [RCW-1:0] rpt_cnt, rpt_next;
  logic           do_step;
  dir_t           step_dir;
  logic           held_level, other_level;
  logic [3:0]     pw_next;
  logic           pw_change;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk_1MHz  (clk_1MHz),
    .rst       (rst),
    .btn_raw   (btn_up),
    .btn_level (up_level),
    .btn_rise  (up_rise)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk_1MHz  (clk_1MHz),
    .rst       (rst),
    .btn_raw   (btn_down),
    .btn_level (dn_level),
    .btn_rise  (dn_rise)
  );

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dir     <= DIR_UP;
      rpt_cnt <= '0;
    end else begin
      state   <= state_next;
      dir     <= dir_next;
      rpt_cnt <= rpt_next;
    end
  end

  // Holding is abandoned, without a step, as soon as the held button drops or the other one joins.
  always_comb begin
    state_next  = state;
    dir_next    = dir;
    rpt_next    = rpt_cnt;
    do_step     = 1'b0;
    step_dir    = dir;
    held_level  = (dir == DIR_UP) ? up_level : dn_level;
    other_level = (dir == DIR_UP) ? dn_level : up_level;
    case (state)
      IDLE: begin
        if (up_rise && !dn_level) begin
          do_step    = 1'b1;
          step_dir   = DIR_UP;
          dir_next   = DIR_UP;
          rpt_next   = '0;
          state_next = HOLD;
        end else if (dn_rise && !up_level) begin
          do_step    = 1'b1;
          step_dir   = DIR_DOWN;
          dir_next   = DIR_DOWN;
          rpt_next   = '0;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!held_level || other_level) begin
          state_next = IDLE;
        end else if (rpt_cnt == DELAY_LAST) begin
          do_step    = 1'b1;
          rpt_next   = '0;
          state_next = REPEAT;
        end else begin
          rpt_next = rpt_cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!held_level || other_level) begin
          state_next = IDLE;
        end else if (rpt_cnt == RATE_LAST) begin
          do_step  = 1'b1;
          rpt_next = '0;
        end else begin
          rpt_next = rpt_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pw_next   = step_value(pulse_width, step_dir);
  assign pw_change = do_step && (pw_next != pulse_width);

  // Limit flags are registered alongside the code so all outputs move in the same cycle.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      pulse_width <= INIT_PW;
      step_pulse  <= 1'b0;
      at_max      <= (INIT_PW == PW_MAX);
      at_min      <= (INIT_PW == PW_MIN);
    end else begin
      step_pulse <= pw_change;
      if (pw_change) begin
        pulse_width <= pw_next;
        at_max      <= (pw_next == PW_MAX);
        at_min      <= (pw_next == PW_MIN);
      end
    end
  end

endmodule

// File: doc/duty_select.md
Name: duty_select

Overview:
- Upstream control stage for the PWM generator. Turns two raw push-buttons (up/down) into the 4-bit pulse_width code that the generator consumes.
- Synchronises and debounces each button, then steps pulse_width once per press and auto-repeats while a button is held. The value saturates at the limits.
- Runs on the same 1 MHz clock as the PWM generator.

Parameters:
- DEBOUNCE_CYCLES, 20000, clocks a synchronised input must stay stable before its debounced level changes (20 ms at 1 MHz)
- REPEAT_DELAY, 500000, clocks a button is held after its first step before auto-repeat begins (0.5 s)
- REPEAT_RATE, 100000, clocks between auto-repeat steps (0.1 s)
- INIT_WIDTH, 5, pulse_width value at reset; must satisfy 0 <= INIT_WIDTH <= 15

Ports:
- clk_1MHz  input  1  system clock, 1 MHz
- rst  input  1  asynchronous active-high reset
- btn_up  input  1  raw, asynchronous, bouncing "increase" button, active-high
- btn_down  input  1  raw, asynchronous, bouncing "decrease" button, active-high
- pulse_width  output  4  duty code fed to the PWM generator, range 0..15
- step_pulse  output  1  one-cycle strobe asserted in the cycle pulse_width changes
- at_max  output  1  high while pulse_width == 15
- at_min  output  1  high while pulse_width == 0

Behaviour:
- Clock and reset:
  - One clock, clk_1MHz; all state is updated on its rising edge.
  - Reset is asynchronous and active-high (rst), and it clears all state immediately.
- Reset values:
  - pulse_width = INIT_WIDTH; step_pulse = 0.
  - at_max and at_min reflect INIT_WIDTH.
  - Synchroniser flops, debounced levels and debounce counters = 0; FSM = IDLE; repeat counter = 0.
- Synchronisation: each button passes through a 2-flop synchroniser before any other logic.
- Debounce, per button:
  - The counter clears whenever the synchronised input equals the current debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the new value and the counter clears.
  - Any bounce back before that point restarts the count.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- Press events: a debounced rising edge on exactly one button is a press. If both debounced levels are high, no steps occur.
- Step rules:
  - up: pulse_width increments only if < 15; down: decrements only if > 0.
  - A step attempted at a limit leaves the value unchanged and does not assert step_pulse.
- FSM (single instance, shared by both buttons), states IDLE, HOLD, REPEAT:
  - IDLE: on a press of exactly one button, step once, clear the repeat counter, record the direction, go to HOLD.
  - HOLD: count to REPEAT_DELAY-1, then step once, clear the counter, go to REPEAT.
  - REPEAT: count to REPEAT_RATE-1, then step once and clear the counter; stay in REPEAT.
  - HOLD or REPEAT: if the recorded button's debounced level falls, or the other button's debounced level rises, go to IDLE with no step. A newly pressed other button must then be released and re-pressed to produce a step.
- Latency:
  - Raw edge to debounced edge = 2 + DEBOUNCE_CYCLES clocks.
  - pulse_width and step_pulse update on the clock edge after the debounced edge is registered, i.e. 1 clock after the debounced level changes.
- Output registration:
  - at_max and at_min are registered and change in the same cycle as pulse_width.
  - pulse_width is glitch-free and changes by at most 1 per clock.
- Reset mid-hold: the block returns to reset values. A button still held when reset is released is seen as a fresh press after the debounce time and steps once.

Decomposition:
- Shared package:
  - PW_MAX = 4'd15, PW_MIN = 4'd0.
  - FSM state typedef {IDLE, HOLD, REPEAT}.
  - Direction enum {DIR_UP, DIR_DOWN}.
- Sub-module button_debouncer, instantiated twice. It contains the 2-flop synchroniser, the debounce counter and the debounced level, plus a one-cycle rise strobe. Parameter: DEBOUNCE_CYCLES. Ports: clk_1MHz, rst, btn_raw, btn_level, btn_rise.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, INIT_WIDTH=5):
- Reset: assert rst mid-cycle -> pulse_width=5, step_pulse=0, at_min=0, at_max=0 immediately (asynchronously).
- Clean press: btn_up high for 10 clocks, then low -> pulse_width=6 at clock 2+4+1=7 after the raw edge; step_pulse high for exactly 1 clock; no further change.
- Bounce: btn_down toggling every 2 clocks for 12 clocks, then stable high for 8 clocks -> exactly one decrement, to 4.
- Auto-repeat: hold btn_up for 60 clocks from pulse_width=5 -> first step to 6, then 7 about 20 clocks later, then +1 every 5 clocks. The value must reach 14 by release and never exceed 15.
- Saturation: from 14 hold btn_up long -> reaches 15, at_max=1, no further step_pulse. From 1, press down twice -> 0, at_min=1, second press gives no step_pulse.
- Conflict and reset: hold btn_up into REPEAT, then raise btn_down -> no further steps. Pulse rst while btn_up is held -> 5, then a single step to 6 after the debounce time.
